// File: rtl/posit_word_packer_if.sv
// Stream bundle between the posit encoder, the word packer and the writeback consumer.
// The packer takes the slave modport; whoever feeds and drains it takes the master modport.
interface posit_word_packer_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
);
    logic                   inValid;
    logic                   inReady;
    logic [WIDTH-1:0]       inData;
    logic                   inLast;
    logic                   flush;
    logic                   outValid;
    logic                   outReady;
    logic [WIDTH*LANES-1:0] outData;
    logic [LANES-1:0]       outKeep;
    logic                   outLast;

    modport slave (
        input  inValid, inData, inLast, flush, outReady,
        output inReady, outValid, outData, outKeep, outLast
    );

    modport master (
        output inValid, inData, inLast, flush, outReady,
        input  inReady, outValid, outData, outKeep, outLast
    );
endinterface

// File: rtl/posit_word_packer.sv
// Packs LANES posits into one output word, with early completion on inLast or flush.
// Defining POSIT_WORD_PACKER_NAR_COUNT_EN adds a saturating tally of NaR input beats.
module posit_word_packer #(
    parameter int WIDTH           = 8,
    parameter int LANES           = 4,
    parameter int NAR_COUNT_WIDTH = 16
) (
    input  logic clock,
    input  logic reset,
`ifdef POSIT_WORD_PACKER_NAR_COUNT_EN
    output logic [NAR_COUNT_WIDTH-1:0] narCount,
`endif
    posit_word_packer_if.slave bus
);
    localparam int FILL_W  = $clog2(LANES);
    localparam int COUNT_W = FILL_W + 1;
    localparam int ACC_W   = (LANES - 1) * WIDTH;
    localparam int WORD_W  = LANES * WIDTH;

    if (LANES < 2 || (LANES & (LANES - 1)) != 0) begin : gBadLanes
        $error("LANES must be a power of two and at least 2");
    end
    if (NAR_COUNT_WIDTH < 1) begin : gBadNarWidth
        $error("NAR_COUNT_WIDTH must be at least 1");
    end

    logic [ACC_W-1:0]  acc;
    logic [FILL_W-1:0] fill;
    logic              outValidReg;
    logic [WORD_W-1:0] outDataReg;
    logic [LANES-1:0]  outKeepReg;
    logic              outLastReg;

    logic              inReady;
    logic              accept;
    logic              complete;
    logic [COUNT_W-1:0] laneCount;
    logic [WORD_W-1:0] wordNext;
    logic [LANES-1:0]  keepNext;
    int                fillInt;

    assign inReady  = !outValidReg || bus.outReady;
    assign accept   = bus.inValid && inReady;
    assign complete = (accept && (fill == FILL_W'(LANES - 1) || bus.inLast || bus.flush))
                   || (bus.flush && inReady && fill != '0);

    // The word as it would look if it completed now: stored lanes plus the current beat.
    always_comb begin
        fillInt   = int'(fill);
        wordNext  = '0;
        wordNext[ACC_W-1:0] = acc;
        if (accept) begin
            wordNext[fillInt*WIDTH +: WIDTH] = bus.inData;
        end
        laneCount = {1'b0, fill} + {{FILL_W{1'b0}}, accept};
        keepNext  = '0;
        for (int i = 0; i < LANES; i++) begin
            keepNext[i] = (i < int'(laneCount));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc         <= '0;
            fill        <= '0;
            outValidReg <= 1'b0;
            outDataReg  <= '0;
            outKeepReg  <= '0;
            outLastReg  <= 1'b0;
        end else if (complete) begin
            outDataReg  <= wordNext;
            outKeepReg  <= keepNext;
            outLastReg  <= accept && bus.inLast;
            outValidReg <= 1'b1;
            acc         <= '0;
            fill        <= '0;
        end else begin
            if (outValidReg && bus.outReady) begin
                outValidReg <= 1'b0;
            end
            if (accept) begin
                acc  <= wordNext[ACC_W-1:0];
                fill <= fill + 1'b1;
            end
        end
    end

`ifdef POSIT_WORD_PACKER_NAR_COUNT_EN
    localparam logic [WIDTH-1:0] NAR_PATTERN = {1'b1, {(WIDTH-1){1'b0}}};

    always_ff @(posedge clock) begin
        if (reset) begin
            narCount <= '0;
        end else if (accept && bus.inData == NAR_PATTERN && narCount != '1) begin
            narCount <= narCount + 1'b1;
        end
    end
`endif

    assign bus.inReady  = inReady;
    assign bus.outValid = outValidReg;
    assign bus.outData  = outDataReg;
    assign bus.outKeep  = outKeepReg;
    assign bus.outLast  = outLastReg;
endmodule
